// File: rtl/uart_sim_pkg.sv
// Shared types and constants for the simulation UART monitor.
package uart_sim_pkg;

  // Receive FSM states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_rx_state_e;

  // End-of-test tokens, first character in the top byte
  localparam logic [31:0] PassToken = 32'h5041_5353;  // "PASS"
  localparam logic [31:0] FailToken = 32'h4641_494C;  // "FAIL"

  // Line terminators clear the match window
  localparam logic [7:0] LfByte = 8'h0A;
  localparam logic [7:0] CrByte = 8'h0D;

endpackage

// File: rtl/uart_sim_monitor_if.sv
// Serial input and decoded status outputs of the UART monitor.
// The monitor takes the slave side; the harness takes the master side.
interface uart_sim_monitor_if;
  logic        rx_i;
  logic [7:0]  byte_o;
  logic        byte_valid_o;
  logic        frame_err_o;
  logic [31:0] byte_count_o;
  logic        pass_o;
  logic        fail_o;

  modport slave  (input  rx_i,
                  output byte_o, byte_valid_o, frame_err_o, byte_count_o, pass_o, fail_o);
  modport master (output rx_i,
                  input  byte_o, byte_valid_o, frame_err_o, byte_count_o, pass_o, fail_o);
endinterface

// File: rtl/uart_sim_rx.sv
// 8N1 deserialiser: 2-flop synchroniser, start/data/stop FSM with baud and
// bit counters. Produces the received byte, a valid pulse and a framing-error
// pulse, each registered so they appear in the cycle after the stop sample.
module uart_sim_rx
  import uart_sim_pkg::*;
#(
  parameter int unsigned ClksPerBit = 48
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int unsigned CntW = $clog2(ClksPerBit);
  localparam logic [CntW-1:0] HalfCnt = CntW'(ClksPerBit / 2 - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(ClksPerBit - 1);

  logic [1:0]     sync_q;
  logic           rx_s;
  logic           rx_prev_q;
  uart_rx_state_e state_q, state_d;
  logic [CntW-1:0] baud_q, baud_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic [7:0]     byte_q, byte_d;
  logic           valid_q, valid_d;
  logic           ferr_q, ferr_d;

  assign rx_s = sync_q[1];

  // Synchroniser and previous-sample flop for falling-edge detection; idle high
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[0], rx_i};
      rx_prev_q <= rx_s;
    end
  end

  // FSM, counter and data registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state: the start bit is checked at half a bit so every later
  // sample falls mid-bit, one full bit period apart
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        if (rx_prev_q && !rx_s) state_d = START;
      end
      START: begin
        if (baud_q == HalfCnt) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = rx_s ? IDLE : DATA;  // high here means a glitch
        end else begin
          baud_d = baud_q + CntW'(1);
        end
      end
      DATA: begin
        if (baud_q == FullCnt) begin
          baud_d  = '0;
          shift_d = {rx_s, shift_q[7:1]};  // LSB first
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + CntW'(1);
        end
      end
      STOP: begin
        if (baud_q == FullCnt) begin
          baud_d = '0;
          if (rx_s) begin
            byte_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end else begin
          baud_d = baud_q + CntW'(1);
        end
      end
      BREAK: begin
        // A held-low line reports once, then waits for idle
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign byte_o       = byte_q;
  assign byte_valid_o = valid_q;
  assign frame_err_o  = ferr_q;

endmodule

// File: rtl/uart_sim_monitor.sv
// Simulation UART monitor: receives 8N1 bytes, counts good bytes, and latches
// the first "PASS"/"FAIL" token seen in the stream.
// Optional macro UART_SIM_MONITOR_PRINT_EN echoes bytes and framing errors
// to the simulator console.
module uart_sim_monitor
  import uart_sim_pkg::*;
#(
  parameter int unsigned SysClkFreq = 45_000_000,
  parameter int unsigned BaudRate   = 921_600
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  uart_sim_monitor_if.slave   bus
);

  localparam int unsigned ClksPerBit = SysClkFreq / BaudRate;

  if (ClksPerBit < 4) begin : g_bad_baud
    $fatal(1, "uart_sim_monitor: ClksPerBit must be at least 4");
  end

  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_ferr;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] win_q, win_d;
  logic        pass_q, pass_d;
  logic        fail_q, fail_d;

  uart_sim_rx #(.ClksPerBit(ClksPerBit)) u_rx (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .rx_i         (bus.rx_i),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_valid),
    .frame_err_o  (rx_ferr)
  );

  // Count, window and sticky flag registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      win_q  <= '0;
      pass_q <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      win_q  <= win_d;
      pass_q <= pass_d;
      fail_q <= fail_d;
    end
  end

  // Token matching uses the post-shift window so a flag is visible in the
  // cycle right after the valid pulse of the token's last character
  always_comb begin
    cnt_d  = cnt_q;
    win_d  = win_q;
    pass_d = pass_q;
    fail_d = fail_q;
    if (rx_valid) begin
      if (cnt_q != '1) cnt_d = cnt_q + 32'd1;
      if (rx_byte == LfByte || rx_byte == CrByte) win_d = '0;
      else                                        win_d = {win_q[23:0], rx_byte};
      if (!pass_q && !fail_q) begin
        if      (win_d == PassToken) pass_d = 1'b1;
        else if (win_d == FailToken) fail_d = 1'b1;
      end
    end
  end

`ifdef UART_SIM_MONITOR_PRINT_EN
  // Echo the byte stream and framing errors to the simulator console
  always @(posedge clk_i) begin
    if (rx_valid) $write("%c", rx_byte);
    if (rx_ferr) $display("*** UART framing error *** at time %t", $time);
  end
`endif

  assign bus.byte_o       = rx_byte;
  assign bus.byte_valid_o = rx_valid;
  assign bus.frame_err_o  = rx_ferr;
  assign bus.byte_count_o = cnt_q;
  assign bus.pass_o       = pass_q;
  assign bus.fail_o       = fail_q;

endmodule

// File: tb/tb_uart_sim_monitor.sv
// Directed bench for uart_sim_monitor at default 48 clocks per bit.
module tb_uart_sim_monitor;
  import uart_sim_pkg::*;

  localparam int Cpb = 45_000_000 / 921_600;  // 48

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_valid = 0;
  int   n_ferr = 0;
  logic prev_v = 1'b0;
  logic pass_after = 1'b0;
  logic fail_after = 1'b0;
  int   v0, f0;

  uart_sim_monitor_if bus ();

  uart_sim_monitor dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  // Pulse counters and flag values one cycle after each valid pulse
  always @(negedge clk_i) begin
    if (prev_v) begin
      pass_after = bus.pass_o;
      fail_after = bus.fail_o;
    end
    prev_v = bus.byte_valid_o;
    if (bus.byte_valid_o) n_valid++;
    if (bus.frame_err_o) n_ferr++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    bus.rx_i = 1'b0;
    wait_clks(Cpb);
    for (int i = 0; i < 8; i++) begin
      bus.rx_i = b[i];
      wait_clks(Cpb);
    end
    bus.rx_i = stop;
    wait_clks(Cpb);
  endtask

  task automatic do_reset();
    bus.rx_i = 1'b1;
    rst_ni = 1'b0;
    wait_clks(3);
    rst_ni = 1'b1;
    wait_clks(3);
  endtask

  initial begin
    bus.rx_i = 1'b1;
    wait_clks(3);
    // Reset values
    check("rst_byte", {24'd0, bus.byte_o}, 32'h0);
    check("rst_valid", {31'd0, bus.byte_valid_o}, 32'h0);
    check("rst_ferr", {31'd0, bus.frame_err_o}, 32'h0);
    check("rst_count", bus.byte_count_o, 32'h0);
    check("rst_pass", {31'd0, bus.pass_o}, 32'h0);
    check("rst_fail", {31'd0, bus.fail_o}, 32'h0);
    rst_ni = 1'b1;
    wait_clks(5);

    // Single frame 0x55
    v0 = n_valid; f0 = n_ferr;
    send_byte(8'h55, 1'b1);
    wait_clks(10);
    check("f55_pulses", n_valid - v0, 1);
    check("f55_byte", {24'd0, bus.byte_o}, 32'h55);
    check("f55_count", bus.byte_count_o, 1);
    check("f55_ferr", n_ferr - f0, 0);

    // "xPASS" back-to-back, then "FAIL" must not disturb the flags
    do_reset();
    send_byte(8'h78, 1'b1);
    send_byte(8'h50, 1'b1);
    send_byte(8'h41, 1'b1);
    send_byte(8'h53, 1'b1);
    send_byte(8'h53, 1'b1);
    wait_clks(5);
    check("pass_count", bus.byte_count_o, 5);
    check("pass_next_cycle", {31'd0, pass_after}, 32'h1);
    check("pass_flag", {31'd0, bus.pass_o}, 32'h1);
    check("pass_nofail", {31'd0, bus.fail_o}, 32'h0);
    send_byte(8'h46, 1'b1);
    send_byte(8'h41, 1'b1);
    send_byte(8'h49, 1'b1);
    send_byte(8'h4C, 1'b1);
    wait_clks(5);
    check("sticky_pass", {31'd0, bus.pass_o}, 32'h1);
    check("sticky_nofail", {31'd0, bus.fail_o}, 32'h0);
    check("sticky_count", bus.byte_count_o, 9);

    // "PA" LF "SS" never matches; a following "FAIL" does
    do_reset();
    send_byte(8'h50, 1'b1);
    send_byte(8'h41, 1'b1);
    send_byte(8'h0A, 1'b1);
    send_byte(8'h53, 1'b1);
    send_byte(8'h53, 1'b1);
    wait_clks(5);
    check("lf_nopass", {31'd0, bus.pass_o}, 32'h0);
    check("lf_count", bus.byte_count_o, 5);
    send_byte(8'h46, 1'b1);
    send_byte(8'h41, 1'b1);
    send_byte(8'h49, 1'b1);
    send_byte(8'h4C, 1'b1);
    wait_clks(5);
    check("fail_next_cycle", {31'd0, fail_after}, 32'h1);
    check("fail_flag", {31'd0, bus.fail_o}, 32'h1);
    check("fail_nopass", {31'd0, bus.pass_o}, 32'h0);

    // 10-cycle low glitch is rejected, next frame is clean
    v0 = n_valid; f0 = n_ferr;
    bus.rx_i = 1'b0;
    wait_clks(10);
    bus.rx_i = 1'b1;
    wait_clks(60);
    check("glitch_valid", n_valid - v0, 0);
    check("glitch_ferr", n_ferr - f0, 0);
    check("glitch_idle", {29'd0, dut.u_rx.state_q}, {29'd0, IDLE});
    send_byte(8'hA3, 1'b1);
    wait_clks(10);
    check("a3_byte", {24'd0, bus.byte_o}, 32'hA3);
    check("a3_count", bus.byte_count_o, 10);
    check("a3_pulses", n_valid - v0, 1);

    // Framing error with held-low line yields one error, then recovery
    do_reset();
    v0 = n_valid; f0 = n_ferr;
    send_byte(8'h41, 1'b0);
    wait_clks(500);
    check("ferr_count_hold", bus.byte_count_o, 0);
    bus.rx_i = 1'b1;
    wait_clks(100);
    send_byte(8'h42, 1'b1);
    wait_clks(10);
    check("ferr_once", n_ferr - f0, 1);
    check("ferr_valid", n_valid - v0, 1);
    check("ferr_byte", {24'd0, bus.byte_o}, 32'h42);
    check("ferr_count", bus.byte_count_o, 1);

    // Reset in the middle of data bit 4 of 0xFF, then 0x12
    v0 = n_valid; f0 = n_ferr;
    bus.rx_i = 1'b0;
    wait_clks(Cpb);
    bus.rx_i = 1'b1;
    wait_clks(4 * Cpb + Cpb / 2);
    rst_ni = 1'b0;
    wait_clks(2);
    check("mid_rst_count", bus.byte_count_o, 0);
    wait_clks(3);
    rst_ni = 1'b1;
    wait_clks(1);
    check("mid_rst_idle", {29'd0, dut.u_rx.state_q}, {29'd0, IDLE});
    wait_clks(6 * Cpb);
    check("mid_rst_nopulse", n_valid - v0, 0);
    check("mid_rst_noferr", n_ferr - f0, 0);
    send_byte(8'h12, 1'b1);
    wait_clks(10);
    check("post_rst_byte", {24'd0, bus.byte_o}, 32'h12);
    check("post_rst_count", bus.byte_count_o, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
